// File: rtl/sys_timer_gpio.sv
// System control peripheral: LED outputs with per-LED blink, debounced switch inputs,
// a prescaled 16-bit reload timer and an active-low level interrupt on the CPU bus.
module sys_timer_gpio #(
   parameter int NLED      = 4,
   parameter int NSW       = 6,
   parameter int PRESCALE  = 40000,
   parameter int DEBOUNCE  = 400000,
   parameter int BLINK_BIT = 22
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cs_b,
   input  logic            rnw,
   input  logic [1:0]      addr,
   input  logic [15:0]     din,
   output logic [15:0]     dout,
   input  logic [NSW-1:0]  sw,
   output logic [NLED-1:0] led,
   output logic            int_b
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tmr_state_t;

   tmr_state_t      state, state_nxt;
   logic [NLED-1:0] led_reg, blink_en;
   logic [23:0]     blink_cnt;
   logic [NSW-1:0]  sync1, sync2, sw_state;
   logic [DB_W-1:0] db_cnt [NSW];
   logic [PS_W-1:0] presc;
   logic [15:0]     count, reload;
   logic            ien, pend;
   logic            wr_en, led_wr, tmr_wr, ctl_wr, tick, expire;

   assign wr_en  = !cs_b && !rnw;
   assign led_wr = wr_en && (addr == 2'd0);
   assign tmr_wr = wr_en && (addr == 2'd2);
   assign ctl_wr = wr_en && (addr == 2'd3);
   // A TMR write in the tick cycle suppresses the decrement and any expiry.
   assign expire = tick && !tmr_wr && (count == 16'h0000);

   // Timer run/idle state register; the state doubles as the ten control bit.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next timer state from CTL writes and prescaler tick detection.
   always_comb begin
      state_nxt = state;
      tick      = 1'b0;
      if (ctl_wr) state_nxt = din[0] ? RUN : IDLE;
      if (state == RUN && presc == PS_LAST) tick = 1'b1;
   end

   // Timer datapath: prescaler, down-counter, reload, pending flag and interrupt output.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc  <= '0;
         count  <= 16'hFFFF;
         reload <= 16'hFFFF;
         ien    <= 1'b0;
         pend   <= 1'b0;
         int_b  <= 1'b1;
      end else begin
         if (state == RUN) presc <= tick ? '0 : presc + 1'b1;
         if (tmr_wr) begin
            reload <= din;
            count  <= din;
            presc  <= '0;
         end else if (tick) begin
            count <= (count == 16'h0000) ? reload : count - 16'd1;
         end
         // Expiry beats a simultaneous software clear so no interrupt is lost.
         if (expire)                pend <= 1'b1;
         else if (ctl_wr && din[15]) pend <= 1'b0;
         if (ctl_wr) ien <= din[1];
         int_b <= !(pend && ien);
      end
   end

   // LED registers, free-running blink counter and registered LED drive.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_reg   <= '0;
         blink_en  <= '0;
         blink_cnt <= '0;
         led       <= '0;
      end else begin
         blink_cnt <= blink_cnt + 24'd1;
         if (led_wr) begin
            led_reg  <= din[NLED-1:0];
            blink_en <= din[8+NLED-1:8];
         end
         led <= (blink_en & {NLED{blink_cnt[BLINK_BIT]}}) | (~blink_en & led_reg);
      end
   end

   // Switch synchroniser and per-bit debounce; a bit only changes after DEBOUNCE
   // consecutive cycles of disagreement with the current debounced state.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         sw_state <= '0;
         for (int i = 0; i < NSW; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
         for (int i = 0; i < NSW; i++) begin
            if (sync2[i] != sw_state[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  sw_state[i] <= sync2[i];
                  db_cnt[i]   <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Combinational read mux; idle bus reads as zero.
   always_comb begin
      dout = 16'h0000;
      if (!cs_b) begin
         case (addr)
            2'd0: begin
               dout[NLED-1:0]   = led_reg;
               dout[8+NLED-1:8] = blink_en;
            end
            2'd1: dout[NSW-1:0] = sw_state;
            2'd2: dout = count;
            default: begin
               dout[0]  = (state == RUN);
               dout[1]  = ien;
               dout[15] = pend;
            end
         endcase
      end
   end

endmodule
